uart_packet_arbiter: RTL

Shares one UART transmitter between the two player-controller packet sources (8-bit packets: bit 7 reset flag, bit 6 unused/zero, bits 5:4 projectile code, bits 3:0 lane). The block sends a packet only when a player's packet changes or a keepalive interval expires, and stamps the player ID into bit 6. It arbitrates round-robin when both players are pending and runs the start/busy handshake with the UART transmitter.

---
 rtl/uart_packet_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_packet_arbiter.sv
// Shares one UART transmitter between two player packet sources: sends on change or keepalive
// expiry, stamps the player ID into bit 6, round-robin on ties, start/busy handshake with timeout.
module uart_packet_arbiter #(
   parameter int KEEPALIVE_CYCLES = 1_000_000,
   parameter int BUSY_TIMEOUT     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] pkt0,
   input  logic [7:0] pkt1,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       last_grant,
   output logic [7:0] coalesce_cnt
);

   localparam int KA_W = $clog2(KEEPALIVE_CYCLES);
   localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [KA_W-1:0] KA_MAX = KA_W'(KEEPALIVE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t          state_reg, state_next;
   logic [7:0]      tx_data_reg, tx_data_next;
   logic            grant_reg, grant_next;
   logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic [7:0]      coal_reg, coal_next;
   logic [8:0]      coal_sum;
   logic            grant_sel;

   logic [1:0][7:0] pkt_in;
   logic [1:0][7:0] masked;
   logic [1:0]      pend;
   logic [1:0]      commit;
   logic [1:0]      coal_hit;
   logic [7:0]      committed;
   logic            unused_bits;

   assign pkt_in      = {pkt1, pkt0};
   assign unused_bits = ^{pkt0[6], pkt1[6]};
   // The byte that was actually handed to the UART, with the ID stripped again.
   assign committed   = {tx_data_reg[7], 1'b0, tx_data_reg[5:0]};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         localparam logic CH = (gi == 1);

         logic [7:0]      last_sent_reg;
         logic [7:0]      prev_reg;
         logic            sent_valid_reg;
         logic            pend_reg, pend_next;
         logic [KA_W-1:0] ka_reg;
         logic            request;

         assign masked[gi]   = {pkt_in[gi][7], 1'b0, pkt_in[gi][5:0]};
         assign commit[gi]   = (state_reg == WAIT_BUSY) && tx_busy && (grant_reg == CH);
         assign request      = !sent_valid_reg || (masked[gi] != last_sent_reg) || (ka_reg == KA_MAX);
         assign pend[gi]     = pend_reg;
         assign coal_hit[gi] = pend_reg && (masked[gi] != prev_reg);

         // A commit overrides a fresh request unless the packet moved on during the transfer.
         always_comb begin
            pend_next = pend_reg;
            if (!enable) begin
               pend_next = 1'b0;
            end else begin
               if (request)
                  pend_next = 1'b1;
               if (commit[gi])
                  pend_next = (masked[gi] != committed);
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               last_sent_reg  <= 8'h00;
               prev_reg       <= 8'h00;
               sent_valid_reg <= 1'b0;
               pend_reg       <= 1'b0;
               ka_reg         <= '0;
            end else begin
               prev_reg <= masked[gi];
               pend_reg <= pend_next;
               if (commit[gi]) begin
                  last_sent_reg  <= committed;
                  sent_valid_reg <= 1'b1;
                  ka_reg         <= '0;
               end else if (ka_reg != KA_MAX) begin
                  ka_reg <= ka_reg + KA_W'(1);
               end
            end
         end
      end
   endgenerate

   assign coal_sum  = {1'b0, coal_reg} + 9'(coal_hit[0]) + 9'(coal_hit[1]);
   assign coal_next = coal_sum[8] ? 8'hFF : coal_sum[7:0];

   always_comb begin
      state_next   = state_reg;
      tx_data_next = tx_data_reg;
      grant_next   = grant_reg;
      to_cnt_next  = to_cnt_reg;
      tx_start     = 1'b0;
      grant_sel    = (pend == 2'b11) ? ~grant_reg : pend[1];
      case (state_reg)
         IDLE: begin
            if (!tx_busy && (pend != 2'b00)) begin
               tx_data_next = {pkt_in[grant_sel][7], grant_sel, pkt_in[grant_sel][5:0]};
               grant_next   = grant_sel;
               state_next   = START;
            end
         end
         START: begin
            tx_start    = 1'b1;
            to_cnt_next = '0;
            state_next  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A timeout abandons the attempt without commit; pend stays set so IDLE retries.
            if (tx_busy)
               state_next = WAIT_DONE;
            else if (to_cnt_reg == TO_MAX)
               state_next = IDLE;
            else
               to_cnt_next = to_cnt_reg + TO_W'(1);
         end
         WAIT_DONE: begin
            if (!tx_busy)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         tx_data_reg <= 8'h00;
         grant_reg   <= 1'b1;
         to_cnt_reg  <= '0;
         coal_reg    <= 8'h00;
      end else begin
         state_reg   <= state_next;
         tx_data_reg <= tx_data_next;
         grant_reg   <= grant_next;
         to_cnt_reg  <= to_cnt_next;
         coal_reg    <= coal_next;
      end
   end

   assign tx_data      = tx_data_reg;
   assign last_grant   = grant_reg;
   assign coalesce_cnt = coal_reg;

endmodule
